// File: rtl/stack_addr_packer_pkg.sv
// Shared definitions for the stack-machine address packer and unpacker.
// ctl encodings, entry field positions, the held-entry record and the pair rule.
package stack_addr_packer_pkg;

  localparam int DATA_WIDTH    = 16;
  localparam int STACK_SIZE    = 3;
  localparam int FLUSH_TIMEOUT = 8;

  localparam int OP_MSB   = 15;
  localparam int OP_LSB   = 12;
  localparam int ADDR_MSB = 7;

  localparam logic [1:0] CTL_IDLE   = 2'b00;
  localparam logic [1:0] CTL_SINGLE = 2'b01;
  localparam logic [1:0] CTL_PAIR   = 2'b11;

  typedef struct packed {
    logic [OP_MSB-OP_LSB:0] op;
    logic [ADDR_MSB:0]      addr;
    logic                   last;
  } entry_t;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2,
    FULL  = 2'd3
  } occ_state_t;

  // A pair word can only be decoded when both entries share the opcode and the
  // partner's upper address nibble repeats it; a burst-final head never pairs.
  function automatic logic is_pairable(entry_t h, entry_t n);
    return (h.op == n.op) && (n.addr[ADDR_MSB -: 4] == h.op) && !h.last;
  endfunction

endpackage

// File: rtl/stack_addr_packer_if.sv
// Entry-in / packed-word-out stream bundle of the address packer.
// master drives entries and consumes words; slave is the packer itself.
interface stack_addr_packer_if;
  import stack_addr_packer_pkg::*;

  logic                  in_valid;
  logic                  in_ready;
  logic [DATA_WIDTH-1:0] in_addr;
  logic                  in_last;
  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] out_data;
  logic [1:0]            out_ctl;

  modport master (
    output in_valid, in_addr, in_last, out_ready,
    input  in_ready, out_valid, out_data, out_ctl
  );

  modport slave (
    input  in_valid, in_addr, in_last, out_ready,
    output in_ready, out_valid, out_data, out_ctl
  );

endinterface

// File: rtl/stack_pack_buf.sv
// STACK_SIZE-deep holding FIFO for the packer: push, pop one or two, peek head/next.
// Slot 0 is always the head; the occupancy state machine is the entry count.
module stack_pack_buf
  import stack_addr_packer_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  entry_t     push_entry,
  input  logic       pop1,
  input  logic       pop2,
  output logic [1:0] count,
  output entry_t     head,
  output entry_t     next
);

  occ_state_t state;
  entry_t     slots     [STACK_SIZE];
  entry_t     slots_nxt [STACK_SIZE];
  logic [1:0] pop_n;
  logic [1:0] count_nxt;
  logic [2:0] wr_pos;
  logic       push_kept;

  assign count     = state;
  assign head      = slots[0];
  assign next      = slots[1];
  assign pop_n     = pop2 ? 2'd2 : (pop1 ? 2'd1 : 2'd0);
  assign count_nxt = count + {1'b0, push} - pop_n;
  assign wr_pos    = {1'b0, count} - {1'b0, pop_n};

  // Popping two with only one held means the incoming entry left as the pair
  // partner in the same cycle, so it is never written into a slot.
  assign push_kept = push && (pop_n <= count);

  always_comb begin
    for (int i = 0; i < STACK_SIZE; i++) begin
      slots_nxt[i] = '0;
      if ((3'(i) + {1'b0, pop_n}) < {1'b0, count}) begin
        slots_nxt[i] = slots[2'(i) + pop_n];
      end
      if (push_kept && (wr_pos == 3'(i))) begin
        slots_nxt[i] = push_entry;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= EMPTY;
      for (int i = 0; i < STACK_SIZE; i++) begin
        slots[i] <= '0;
      end
    end else begin
      state <= occ_state_t'(count_nxt);
      slots <= slots_nxt;
    end
  end

endmodule

// File: rtl/stack_addr_packer.sv
// Packs a stream of 16-bit address entries into single (ctl=01) and pair (ctl=11) words.
// Optional idle flush of a lone entry is built when STACK_PACK_TIMEOUT_EN is defined.
module stack_addr_packer
  import stack_addr_packer_pkg::*;
(
  input  logic clk,
  input  logic rst,
  stack_addr_packer_if.slave bus
);

  localparam logic [1:0] FULL_COUNT = 2'(STACK_SIZE);

  entry_t                in_entry;
  entry_t                head;
  entry_t                next;
  entry_t                partner;
  logic [1:0]            count;
  logic                  accept;
  logic                  can_load;
  logic                  emit_pair;
  logic                  emit_single;
  logic                  pop1;
  logic                  pop2;
  logic                  timeout_hit;
  logic                  out_valid_q;
  logic [DATA_WIDTH-1:0] out_data_q;
  logic [1:0]            out_ctl_q;
  logic                  unused_addr_bits;

  assign in_entry         = {bus.in_addr[OP_MSB:OP_LSB], bus.in_addr[ADDR_MSB:0], bus.in_last};
  assign unused_addr_bits = ^bus.in_addr[OP_LSB-1:ADDR_MSB+1];

  assign bus.in_ready  = (count < FULL_COUNT);
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_ctl   = out_ctl_q;

  assign accept   = bus.in_valid && bus.in_ready;
  assign can_load = !out_valid_q || bus.out_ready;
  assign pop1     = can_load && emit_single;
  assign pop2     = can_load && emit_pair;

  stack_pack_buf u_buf (
    .clk        (clk),
    .rst        (rst),
    .push       (accept),
    .push_entry (in_entry),
    .pop1       (pop1),
    .pop2       (pop2),
    .count      (count),
    .head       (head),
    .next       (next)
  );

  // With a single entry held, the entry being accepted right now may serve as
  // its partner, so back-to-back pairable entries leave two cycles after the first.
  assign partner = (count >= 2'd2) ? next : in_entry;

  always_comb begin
    emit_pair   = 1'b0;
    emit_single = 1'b0;
    if (count >= 2'd2) begin
      if (is_pairable(head, next)) begin
        emit_pair = 1'b1;
      end else begin
        emit_single = 1'b1;
      end
    end else if (count == 2'd1) begin
      if (accept && is_pairable(head, in_entry)) begin
        emit_pair = 1'b1;
      end else if (head.last || timeout_hit) begin
        emit_single = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_ctl_q   <= CTL_IDLE;
    end else if (can_load) begin
      if (emit_pair) begin
        out_valid_q <= 1'b1;
        out_data_q  <= {partner.addr, head.addr};
        out_ctl_q   <= CTL_PAIR;
      end else if (emit_single) begin
        out_valid_q <= 1'b1;
        out_data_q  <= {head.op, 4'h0, head.addr};
        out_ctl_q   <= CTL_SINGLE;
      end else begin
        out_valid_q <= 1'b0;
        out_data_q  <= '0;
        out_ctl_q   <= CTL_IDLE;
      end
    end
  end

`ifdef STACK_PACK_TIMEOUT_EN
  localparam int                  TIMER_W   = $clog2(FLUSH_TIMEOUT + 1);
  localparam logic [TIMER_W-1:0]  TIMER_MAX = TIMER_W'(FLUSH_TIMEOUT);

  logic [TIMER_W-1:0] idle_timer;

  // Saturates so a lone entry blocked behind a stalled output still flushes
  // as soon as the output register frees up.
  always_ff @(posedge clk) begin
    if (rst || accept || pop1 || pop2) begin
      idle_timer <= '0;
    end else if ((count == 2'd1) && !head.last && (idle_timer != TIMER_MAX)) begin
      idle_timer <= idle_timer + TIMER_W'(1);
    end
  end

  assign timeout_hit = (idle_timer == TIMER_MAX);
`else
  assign timeout_hit = 1'b0;
`endif

endmodule

// File: tb/tb_stack_addr_packer.sv
// Self-checking bench for stack_addr_packer: directed vectors, corner sequences,
// and a randomized stream checked against a stream-level packing model.
module tb_stack_addr_packer;
  import stack_addr_packer_pkg::*;

  typedef struct {
    logic [15:0] addr;
    logic        last;
  } in_t;

  typedef struct {
    logic [15:0] data;
    logic [1:0]  ctl;
  } word_t;

  typedef in_t   in_q_t[$];
  typedef word_t word_q_t[$];

  typedef struct {
    logic [15:0] a0;
    logic        l0;
    logic [15:0] a1;
    int          n;
    logic [15:0] d0;
    logic [1:0]  c0;
    logic [15:0] d1;
    logic [1:0]  c1;
  } vec_t;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  stack_addr_packer_if bus ();

  stack_addr_packer dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int      errors = 0;
  int      checks = 0;
  in_q_t   send_q;
  word_q_t got_q;
  word_q_t exp_q;
  vec_t    vecs [8];
  int      first_seen;
  int      high_cnt;
  int      low_run;
  bit      v_en;
  bit      r_en;
  logic [15:0] bp_words [5];

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
    end
  endtask

  // One cycle: drive at the falling edge, record the handshakes the next rising edge will take.
  task automatic applyStimulus(input bit valid_en, input bit rdy);
    @(negedge clk);
    bus.out_ready = rdy;
    if (valid_en && (send_q.size() > 0)) begin
      bus.in_valid = 1'b1;
      bus.in_addr  = send_q[0].addr;
      bus.in_last  = send_q[0].last;
    end else begin
      bus.in_valid = 1'b0;
      bus.in_last  = 1'b0;
    end
    if (!bus.out_valid) checkOutput("idle_ctl", 32'(bus.out_ctl), 32'(CTL_IDLE));
    if (bus.in_valid && bus.in_ready) send_q.delete(0);
    if (bus.out_valid && bus.out_ready) got_q.push_back('{data: bus.out_data, ctl: bus.out_ctl});
  endtask

  task automatic runUntil(input int n, input int budget);
    for (int k = 0; k < budget; k++) begin
      if (got_q.size() >= n) break;
      applyStimulus(1'b1, 1'b1);
    end
    repeat (3) applyStimulus(1'b1, 1'b1);
  endtask

  task automatic checkWord(input string name, input int idx, input logic [15:0] d, input logic [1:0] c);
    if (idx < got_q.size()) begin
      checkOutput({name, "_data"}, 32'(got_q[idx].data), 32'(d));
      checkOutput({name, "_ctl"}, 32'(got_q[idx].ctl), 32'(c));
    end
  endtask

  task automatic doReset();
    @(negedge clk);
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_last   = 1'b0;
    bus.out_ready = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    send_q.delete();
    got_q.delete();
  endtask

  // Stream-level packing: walk entries in arrival order, pair greedily by the pair rule.
  function automatic word_q_t buildExpected(input in_q_t ins);
    word_q_t w;
    int      i;
    w = {};
    i = 0;
    while (i < ins.size()) begin
      if (!ins[i].last && (i + 1 < ins.size()) &&
          (ins[i].addr[15:12] == ins[i+1].addr[15:12]) &&
          (ins[i+1].addr[7:4] == ins[i].addr[15:12])) begin
        w.push_back('{data: {ins[i+1].addr[7:0], ins[i].addr[7:0]}, ctl: 2'b11});
        i += 2;
      end else begin
        w.push_back('{data: {ins[i].addr[15:12], 4'h0, ins[i].addr[7:0]}, ctl: 2'b01});
        i += 1;
      end
    end
    return w;
  endfunction

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    vecs[0] = '{16'h3012, 1'b0, 16'h303A, 1, 16'h3A12, CTL_PAIR,   16'h0000, CTL_IDLE};
    vecs[1] = '{16'h3012, 1'b0, 16'h4015, 2, 16'h3012, CTL_SINGLE, 16'h4015, CTL_SINGLE};
    vecs[2] = '{16'h3F12, 1'b0, 16'h3A3A, 1, 16'h3A12, CTL_PAIR,   16'h0000, CTL_IDLE};
    vecs[3] = '{16'h5077, 1'b1, 16'h5050, 2, 16'h5077, CTL_SINGLE, 16'h5050, CTL_SINGLE};
    vecs[4] = '{16'h7011, 1'b0, 16'h7022, 2, 16'h7011, CTL_SINGLE, 16'h7022, CTL_SINGLE};
    vecs[5] = '{16'h2011, 1'b0, 16'h3021, 2, 16'h2011, CTL_SINGLE, 16'h3021, CTL_SINGLE};
    vecs[6] = '{16'h0000, 1'b0, 16'h0005, 1, 16'h0500, CTL_PAIR,   16'h0000, CTL_IDLE};
    vecs[7] = '{16'hF0F0, 1'b0, 16'hF0FF, 1, 16'hFFF0, CTL_PAIR,   16'h0000, CTL_IDLE};
    bp_words = '{16'h1011, 16'h2022, 16'h3033, 16'h4044, 16'h5055};

    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_addr   = '0;
    bus.in_last   = 1'b0;
    bus.out_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    checkOutput("rst_out_valid", 32'(bus.out_valid), 32'h0);
    checkOutput("rst_out_data", 32'(bus.out_data), 32'h0);
    checkOutput("rst_out_ctl", 32'(bus.out_ctl), 32'h0);
    checkOutput("rst_in_ready", 32'(bus.in_ready), 32'h1);

    // Pair accepted on consecutive cycles shows up two cycles after the first
    send_q.push_back('{addr: 16'h3012, last: 1'b0});
    send_q.push_back('{addr: 16'h303A, last: 1'b0});
    applyStimulus(1'b1, 1'b1);
    checkOutput("pair_rdy0", 32'(bus.in_ready), 32'h1);
    applyStimulus(1'b1, 1'b1);
    checkOutput("pair_n1_valid", 32'(bus.out_valid), 32'h0);
    checkOutput("pair_rdy1", 32'(bus.in_ready), 32'h1);
    applyStimulus(1'b1, 1'b1);
    checkOutput("pair_n2_valid", 32'(bus.out_valid), 32'h1);
    checkOutput("pair_n2_data", 32'(bus.out_data), 32'h3A12);
    checkOutput("pair_n2_ctl", 32'(bus.out_ctl), 32'(CTL_PAIR));
    checkOutput("pair_rdy2", 32'(bus.in_ready), 32'h1);
    applyStimulus(1'b1, 1'b1);
    checkOutput("pair_no_dup", 32'(bus.out_valid), 32'h0);

    // Burst-final entry flushes without waiting for a partner
    send_q.push_back('{addr: 16'h5077, last: 1'b1});
    applyStimulus(1'b1, 1'b1);
    applyStimulus(1'b1, 1'b1);
    checkOutput("last_n1_valid", 32'(bus.out_valid), 32'h0);
    applyStimulus(1'b1, 1'b1);
    checkOutput("last_n2_valid", 32'(bus.out_valid), 32'h1);
    checkOutput("last_n2_data", 32'(bus.out_data), 32'h5077);
    checkOutput("last_n2_ctl", 32'(bus.out_ctl), 32'(CTL_SINGLE));
    applyStimulus(1'b1, 1'b1);

    for (int v = 0; v < 8; v++) begin
      got_q.delete();
      send_q.push_back('{addr: vecs[v].a0, last: vecs[v].l0});
      send_q.push_back('{addr: vecs[v].a1, last: 1'b1});
      runUntil(vecs[v].n, 20);
      checkOutput($sformatf("vec%0d_count", v), 32'(got_q.size()), 32'(vecs[v].n));
      checkWord($sformatf("vec%0d_w0", v), 0, vecs[v].d0, vecs[v].c0);
      if (vecs[v].n > 1) checkWord($sformatf("vec%0d_w1", v), 1, vecs[v].d1, vecs[v].c1);
    end

    // Opcode mismatch: head goes alone, the trailing entry waits for a flush
    got_q.delete();
    send_q.push_back('{addr: 16'h3012, last: 1'b0});
    send_q.push_back('{addr: 16'h4015, last: 1'b0});
    for (int k = 0; k < 6; k++) applyStimulus(1'b1, 1'b1);
    checkOutput("mis_first_count", 32'(got_q.size()), 32'd1);
    checkWord("mis_w0", 0, 16'h3012, CTL_SINGLE);
`ifdef STACK_PACK_TIMEOUT_EN
    runUntil(2, 30);
    checkOutput("mis_timeout_count", 32'(got_q.size()), 32'd2);
    checkWord("mis_w1", 1, 16'h4015, CTL_SINGLE);
`else
    for (int k = 0; k < 20; k++) applyStimulus(1'b1, 1'b1);
    checkOutput("mis_held_count", 32'(got_q.size()), 32'd1);
    send_q.push_back('{addr: 16'h6066, last: 1'b1});
    runUntil(3, 20);
    checkOutput("mis_flush_count", 32'(got_q.size()), 32'd3);
    checkWord("mis_w1", 1, 16'h4015, CTL_SINGLE);
    checkWord("mis_w2", 2, 16'h6066, CTL_SINGLE);
`endif

    // Backpressure: three buffered plus one in the output register, then drain in order
    got_q.delete();
    for (int k = 0; k < 5; k++) send_q.push_back('{addr: bp_words[k], last: (k == 4)});
    for (int k = 0; k < 12; k++) begin
      applyStimulus(1'b1, 1'b0);
      if (bus.out_valid) checkOutput("bp_hold_data", 32'(bus.out_data), 32'h1011);
    end
    checkOutput("bp_in_ready", 32'(bus.in_ready), 32'h0);
    checkOutput("bp_out_valid", 32'(bus.out_valid), 32'h1);
    checkOutput("bp_pending", 32'(send_q.size()), 32'd1);
    runUntil(5, 30);
    checkOutput("bp_count", 32'(got_q.size()), 32'd5);
    for (int k = 0; k < 5; k++) checkWord($sformatf("bp_w%0d", k), k, bp_words[k], CTL_SINGLE);

    // Lone non-final entry with the input idle
    got_q.delete();
    send_q.push_back('{addr: 16'h2001, last: 1'b0});
    applyStimulus(1'b1, 1'b1);
    first_seen = -1;
    high_cnt   = 0;
`ifdef STACK_PACK_TIMEOUT_EN
    for (int k = 1; k <= 20; k++) begin
      applyStimulus(1'b0, 1'b1);
      if (bus.out_valid && (first_seen < 0)) first_seen = k;
    end
    checkOutput("tmo_delay_window", 32'((first_seen >= 9) && (first_seen <= 11)), 32'h1);
    checkOutput("tmo_count", 32'(got_q.size()), 32'd1);
    checkWord("tmo_w0", 0, 16'h2001, CTL_SINGLE);
`else
    for (int k = 0; k < 100; k++) begin
      applyStimulus(1'b0, 1'b1);
      if (bus.out_valid) high_cnt++;
    end
    checkOutput("no_tmo_valid_cycles", 32'(high_cnt), 32'd0);
`endif

    // Reset with entries buffered and a word pending
    send_q.push_back('{addr: 16'h3012, last: 1'b0});
    send_q.push_back('{addr: 16'h4015, last: 1'b0});
    for (int k = 0; k < 4; k++) applyStimulus(1'b1, 1'b0);
    doReset();
    checkOutput("mid_rst_out_valid", 32'(bus.out_valid), 32'h0);
    checkOutput("mid_rst_out_ctl", 32'(bus.out_ctl), 32'h0);
    checkOutput("mid_rst_out_data", 32'(bus.out_data), 32'h0);
    checkOutput("mid_rst_in_ready", 32'(bus.in_ready), 32'h1);
    for (int k = 0; k < 20; k++) applyStimulus(1'b1, 1'b1);
    checkOutput("mid_rst_no_stale", 32'(got_q.size()), 32'd0);
    send_q.push_back('{addr: 16'h5077, last: 1'b1});
    runUntil(1, 20);
    checkOutput("mid_rst_after_count", 32'(got_q.size()), 32'd1);
    checkWord("mid_rst_after", 0, 16'h5077, CTL_SINGLE);

    // Randomized stream with random valid/ready against the packing model
    doReset();
    for (int k = 0; k < 120; k++) begin
      send_q.push_back('{addr: {4'($urandom_range(0, 3)), 4'($urandom_range(0, 15)),
                                4'($urandom_range(0, 3)), 4'($urandom_range(0, 15))},
                         last: (k == 119) || ($urandom_range(0, 9) == 0)});
    end
    exp_q   = buildExpected(send_q);
    low_run = 0;
    for (int k = 0; k < 3000; k++) begin
      if ((got_q.size() >= exp_q.size()) && (send_q.size() == 0)) break;
      v_en = ($urandom_range(0, 3) != 0) || (low_run >= 3);
      r_en = ($urandom_range(0, 9) < 7);
      low_run = v_en ? 0 : low_run + 1;
      applyStimulus(v_en, r_en);
    end
    repeat (5) applyStimulus(1'b1, 1'b1);
    checkOutput("rnd_count", 32'(got_q.size()), 32'(exp_q.size()));
    for (int k = 0; k < exp_q.size(); k++) begin
      checkWord($sformatf("rnd_w%0d", k), k, exp_q[k].data, exp_q[k].ctl);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/stack_addr_packer.md
# stack_addr_packer

Transmit-side counterpart of the stack-machine address unpacker: accepts a stream of unpacked 16-bit address entries and packs them into the control-word format that the unpacker consumes. Pairable entries go out as one two-address word (ctl=11); the rest go out as single-address words (ctl=01). It has a 3-entry holding buffer, valid/ready flow control on both sides and a flush on last.

## Interface
- DATA_WIDTH, 16: entry and packed word width; fixed at 16 in this revision.
- STACK_SIZE, 3: holding-buffer depth in entries.
- FLUSH_TIMEOUT, 8: idle cycles before a lone held entry is sent as a single (only with the timeout macro).
- clk  in  1  clock; the block uses one clock only.
- rst  in  1  reset; synchronous, active-high.
- in_valid  in  1  entry offered.
- in_ready  out  1  buffer can accept an entry.
- in_addr  in  16  entry {op[3:0], 4'b0, addr[7:0]}; bits [11:8] are ignored.
- in_last  in  1  final entry of a burst; forces a flush.
- out_valid  out  1  packed word valid.
- out_ready  in  1  downstream accepts.
- out_data  out  16  packed word.
- out_ctl  out  2  01 = single, 11 = pair; 00 when out_valid is low.

## Operation
- Accept: an entry is accepted when in_valid && in_ready. in_ready = (occupancy < STACK_SIZE), decoded combinationally from the registered occupancy.
- Buffer: FIFO order. Each slot stores {op, addr, last}.
- Pair rule: head H and next N are pairable when all of these hold:
  - H.op == N.op
  - N.addr[7:4] == H.op
  - H.last == 0
- Pair output: out_data = {N.addr, H.addr}, out_ctl = 11. Two entries are popped.
- Single output: out_data = {H.op, 4'b0, H.addr}, out_ctl = 01. One entry is popped.
- Decision, evaluated when the output register is empty or out_ready is high:
  - 2 or more entries held, pairable: emit pair.
  - 2 or more entries held, not pairable: emit single of H.
  - 1 entry held with H.last = 1: emit single.
  - 1 entry held with the timeout expired: emit single.
  - Otherwise: hold.
- State machine, derived from occupancy plus the timer:
  - EMPTY → ONE on a push.
  - ONE → TWO on a push without a pop.
  - TWO → FULL on a push without a pop.
  - Pops move it back down by 1 or 2.
  - A push and a pop in the same cycle are legal; net occupancy = old + push − pop.
- Output register: holds its value while out_valid && !out_ready. A new word loads only on a handshake or while the register is empty.
- Full: in_ready = 0 and no entry is overwritten. An in_valid presented while full is ignored; upstream holds it.
- Reset mid-operation: all held entries and the pending output are discarded. The timer clears.

## Timing
- Reset values:
  - out_valid = 0, out_data = 16'h0000, out_ctl = 2'b00.
  - Occupancy = 0, so in_ready = 1 during the first cycle after reset.
  - Timer = 0.
- Latency: an entry accepted at cycle N can appear on out_data at N+2 at the earliest (buffer register, then output register).
- A pair whose entries are accepted at N and N+1 appears at N+2.
- Throughput: one packed word per cycle, provided out_ready stays high.
- Timer behaviour:
  - Increments while occupancy == 1, H.last == 0 and there is no push.
  - Clears on any push, pop or reset.
  - At FLUSH_TIMEOUT the single is emitted in the next decision cycle.

## Configuration
- STACK_PACK_TIMEOUT_EN defined: the timer is present and a lone entry is flushed after FLUSH_TIMEOUT idle cycles.
- STACK_PACK_TIMEOUT_EN undefined: no timer logic is built. A lone non-last entry waits indefinitely for a partner or for in_last, and FLUSH_TIMEOUT is unused.

## Structure
- Shared package holds:
  - ctl encodings: CTL_IDLE=2'b00, CTL_SINGLE=2'b01, CTL_PAIR=2'b11.
  - Entry field positions: OP_MSB=15, OP_LSB=12, ADDR_MSB=7.
  - The entry struct {op, addr, last}.
- The unpacker imports the same package.
- Sub-module: stack_pack_buf, the STACK_SIZE-entry FIFO with push/pop-1/pop-2 and head/next peek. Pairing logic and the output register stay in the top level.

## Test plan
- Pair packing: accept 16'h3012, then 16'h303A with out_ready=1.
  - Expect one word 16'h3A12 with ctl=11 at cycle N+2.
  - Expect in_ready=1 throughout.
- Op mismatch: accept 16'h3012, then 16'h4015.
  - Expect 16'h3012 with ctl=01, then 16'h4015 with ctl=01 once it is flushed by in_last or the timeout.
- Flush on last: accept 16'h5077 with in_last=1.
  - Expect 16'h5077 with ctl=01 at N+2, and no wait for a partner.
- Backpressure and full: hold out_ready=0 and offer 5 entries.
  - Expect in_ready=0 after 3 buffered entries plus the output register is occupied.
  - out_data stays stable.
  - After out_ready is released, every entry is delivered in order with no loss or duplicates.
- Timeout (macro on, FLUSH_TIMEOUT=8): accept a lone 16'h2001 and keep in_valid low.
  - Expect 16'h2001 with ctl=01 after 8 idle cycles.
  - With the macro off, out_valid stays 0 for 100 cycles.
- Reset mid-operation: buffer 2 entries, then assert rst for 1 cycle.
  - Expect out_valid=0, out_ctl=00, out_data=0 and in_ready=1 next cycle.
  - Expect no stale word afterwards.
